// File: rtl/avalon_pio_pkg.sv
// Shared types and constants for the Avalon PIO poller.
package avalon_pio_pkg;

    localparam int PIO_ADDR_W = 2;

    localparam logic [PIO_ADDR_W-1:0] PIO_DATA      = 2'd0;
    localparam logic [PIO_ADDR_W-1:0] PIO_DIRECTION = 2'd1;
    localparam logic [PIO_ADDR_W-1:0] PIO_IRQMASK   = 2'd2;
    localparam logic [PIO_ADDR_W-1:0] PIO_EDGECAP   = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2,
        EVAL = 2'd3
    } poll_state_e;

endpackage

// File: rtl/pio_debounce_bit.sv
// One-bit debouncer: tracks a candidate value and its run length, commits it
// to the stable level after DEBOUNCE_COUNT equal samples, pulses rise/fall.
module pio_debounce_bit #(
    parameter int DEBOUNCE_COUNT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic eval_i,
    input  logic sample_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int CW = $clog2(DEBOUNCE_COUNT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_COUNT);

    logic          cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    always_comb begin
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (eval_i) begin
            if (sample_i == cand_q) begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end else begin
                cand_d = sample_i;
                cnt_d  = CW'(1);
            end
            // Decision uses the post-update candidate and count.
            if (cnt_d == CNT_MAX && cand_d != level_q) begin
                level_d = cand_d;
                rise_d  = cand_d;
                fall_d  = ~cand_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand_q  <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/avalon_pio_poller.sv
// Avalon-MM master that periodically reads a PIO data register, debounces
// each bit and raises a sticky rising-edge interrupt.
//
// state | meaning
// IDLE  | waiting for a pending poll request
// READ  | m_read asserted until the slave accepts
// WAIT  | counting read latency, captures m_readdata at the end
// EVAL  | one-cycle debounce update strobe
module avalon_pio_poller
    import avalon_pio_pkg::*;
#(
    parameter int WIDTH          = 1,
    parameter int POLL_PERIOD    = 50000,
    parameter int DEBOUNCE_COUNT = 4,
    parameter int READ_LATENCY   = 1,
    parameter int PIO_ADDR       = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    output logic [PIO_ADDR_W-1:0] m_address,
    output logic                  m_read,
    input  logic                  m_waitrequest,
    input  logic [WIDTH-1:0]      m_readdata,
    output logic [WIDTH-1:0]      level,
    output logic [WIDTH-1:0]      rise,
    output logic [WIDTH-1:0]      fall,
    input  logic [WIDTH-1:0]      clr,
    output logic                  irq
);
    localparam int TW = $clog2(POLL_PERIOD);
    localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(POLL_PERIOD - 1);
    localparam logic [LW-1:0] LAT_RELOAD   = LW'(READ_LATENCY - 1);

    poll_state_e      state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             pending_q, pending_d;
    logic [LW-1:0]    lat_q, lat_d;
    logic [WIDTH-1:0] sample_q, sample_d;
    logic [WIDTH-1:0] flags_q, flags_d;
    logic             irq_q;
    logic             timer_expire;

    assign timer_expire = enable && (timer_q == '0);

    always_comb begin
        timer_d = timer_q;
        if (enable) begin
            timer_d = timer_expire ? TIMER_RELOAD : timer_q - 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        lat_d     = lat_q;
        sample_d  = sample_q;
        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    pending_d = 1'b0;
                    state_d   = READ;
                end
            end
            READ: begin
                if (!m_waitrequest) begin
                    lat_d   = LAT_RELOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (lat_q == '0) begin
                    sample_d = m_readdata;
                    state_d  = EVAL;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            EVAL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A fresh expiry always wins over the IDLE consume; at most one is held.
        if (timer_expire) pending_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            timer_q   <= TIMER_RELOAD;
            pending_q <= 1'b0;
            lat_q     <= '0;
            sample_q  <= '0;
            flags_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            lat_q     <= lat_d;
            sample_q  <= sample_d;
            flags_q   <= flags_d;
            irq_q     <= |flags_q;
        end
    end

    assign flags_d   = (flags_q & ~clr) | rise;
    assign m_read    = (state_q == READ);
    assign m_address = PIO_ADDR_W'(PIO_ADDR);
    assign irq       = irq_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce_bit #(
            .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .eval_i  (state_q == EVAL),
            .sample_i(sample_q[i]),
            .level_o (level[i]),
            .rise_o  (rise[i]),
            .fall_o  (fall[i])
        );
    end

endmodule

// File: tb/tb_avalon_pio_poller.sv
// Randomized bench for avalon_pio_poller against a transaction-level model,
// plus directed cycle-exact expectations for the main scenarios.
module tb_avalon_pio_poller;
    localparam int W  = 2;
    localparam int P  = 8;
    localparam int D  = 3;
    localparam int RL = 2;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         enable;
    logic [1:0]   m_address;
    logic         m_read;
    logic         m_waitrequest;
    logic [W-1:0] m_readdata;
    logic [W-1:0] level;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] clr;
    logic         irq;

    always #5 clk = ~clk;

    avalon_pio_poller #(
        .WIDTH(W), .POLL_PERIOD(P), .DEBOUNCE_COUNT(D),
        .READ_LATENCY(RL), .PIO_ADDR(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .m_address(m_address), .m_read(m_read), .m_waitrequest(m_waitrequest),
        .m_readdata(m_readdata), .level(level), .rise(rise), .fall(fall),
        .clr(clr), .irq(irq)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Model: timer/pending, a read-in-progress flag, age since acceptance,
    // and a history of the last D samples per debounce decision.
    int           timer;
    bit           pending;
    bit           reading;
    int           acc_age;
    logic [W-1:0] sample;
    logic [W-1:0] hist[$];
    logic [W-1:0] lvl, rs, fl, flags;
    logic         irq_m;
    logic [W-1:0] pin;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        timer = P - 1; pending = 0; reading = 0; acc_age = -1;
        sample = '0; hist.delete();
        lvl = '0; rs = '0; fl = '0; flags = '0; irq_m = 1'b0;
    endtask

    task automatic model_step();
        bit           expire, n_reading, n_pending;
        int           n_acc, ones;
        logic [W-1:0] n_lvl, n_rs, n_fl;
        expire = enable && (timer == 0);
        n_reading = reading; n_pending = pending; n_acc = acc_age;
        n_lvl = lvl; n_rs = '0; n_fl = '0;
        if (reading) begin
            if (!m_waitrequest) begin n_reading = 0; n_acc = 1; end
        end else if (acc_age == RL) begin
            sample = m_readdata;
            n_acc = acc_age + 1;
        end else if (acc_age == RL + 1) begin
            hist.push_back(sample);
            if (hist.size() > D) void'(hist.pop_front());
            for (int i = 0; i < W; i++) begin
                ones = 0;
                foreach (hist[j]) ones += int'(hist[j][i]);
                if (hist.size() == D && ones == D && !lvl[i]) begin n_lvl[i] = 1'b1; n_rs[i] = 1'b1; end
                if (hist.size() == D && ones == 0 && lvl[i])  begin n_lvl[i] = 1'b0; n_fl[i] = 1'b1; end
            end
            n_acc = -1;
        end else if (acc_age >= 1) begin
            n_acc = acc_age + 1;
        end else if (pending) begin
            n_reading = 1; n_pending = 0;
        end
        if (expire) n_pending = 1;
        if (enable) timer = (timer == 0) ? P - 1 : timer - 1;
        irq_m = |flags;
        flags = (flags & ~clr) | rs;
        reading = n_reading; pending = n_pending; acc_age = n_acc;
        lvl = n_lvl; rs = n_rs; fl = n_fl;
    endtask

    task automatic compare_all();
        chk("m_read", m_read, reading);
        chk("m_address", m_address, 0);
        chk("level", level, lvl);
        chk("rise", rise, rs);
        chk("fall", fall, fl);
        chk("irq", irq, irq_m);
    endtask

    task automatic begin_cycle();
        @(negedge clk);
        compare_all();
    endtask

    task automatic end_cycle(input bit en, input bit wr, input logic [W-1:0] c,
                             input logic [W-1:0] p, input bit junk);
        enable = en; m_waitrequest = wr; clr = c;
        m_readdata = (junk && acc_age != RL) ? W'($urandom) : p;
        @(posedge clk);
        model_step();
        cyc++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  rd;
        bit  found;
        reset_n = 1'b0; enable = 1'b0; m_waitrequest = 1'b0;
        clr = '0; m_readdata = '0; pin = 2'b01;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        rd = 0;
        for (int c = 0; c < 64; c++) begin
            begin_cycle();
            case (c)
                0:  begin chk("rst_level", level, 0); chk("rst_irq", irq, 0); end
                8:  chk("first_read_early", m_read, 0);
                9:  chk("first_read", m_read, 1);
                10: chk("first_read_len", m_read, 0);
                17: chk("second_read", m_read, 1);
                28: chk("level_before", level, 2'b00);
                29: begin
                        chk("level_rise", level, 2'b01);
                        chk("rise_pulse", rise, 2'b01);
                        chk("no_fall", fall, 2'b00);
                    end
                30: begin chk("rise_one_cycle", rise, 2'b00); chk("irq_lag", irq, 0); end
                31: chk("irq_set_wins", irq, 1);
                41: chk("irq_before_clr", irq, 1);
                42: chk("irq_cleared", irq, 0);
                48: chk("glitch_ignored", level, 2'b01);
                54: chk("stall_accept", m_read, 1);
                55: chk("stall_done", m_read, 0);
                58: chk("stall_len", rd, 6);
                59: chk("overrun_reissue", m_read, 1);
                default: ;
            endcase
            if (c >= 49 && c <= 57) rd += int'(m_read);
            end_cycle(1'b1, (c >= 49 && c <= 53), (c == 29 || c == 40) ? 2'b01 : 2'b00,
                      (c >= 33 && c <= 40) ? 2'b11 : 2'b01, 1'b0);
        end

        for (int c = 0; c < 2900; c++) begin
            begin_cycle();
            if ($urandom_range(29, 0) == 0) pin = W'($urandom);
            end_cycle($urandom_range(15, 0) != 0, $urandom_range(2, 0) == 0,
                      ($urandom_range(7, 0) == 0) ? W'($urandom) : '0, pin, 1'b1);
        end

        found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            begin_cycle();
            if (reading) found = 1;
            else end_cycle(1'b1, 1'b0, '0, pin, 1'b1);
        end
        if (found) begin
            reset_n = 1'b0;
            #1;
            chk("rst_drops_read", m_read, 0);
            chk("rst_level_clr", level, 0);
            chk("rst_rise_clr", rise, 0);
            chk("rst_fall_clr", fall, 0);
            chk("rst_irq_clr", irq, 0);
            model_reset();
            repeat (2) @(posedge clk);
            #1 reset_n = 1'b1;
        end else begin
            n_checks++; n_err++;
            $display("FAIL find_read cycle=%0d actual=no_read required=read_within_100", cyc);
        end

        rd = 0;
        for (int k = 0; k < 3 * P; k++) begin
            begin_cycle();
            rd += int'(m_read);
            end_cycle(1'b0, $urandom_range(1, 0) == 1, '0, pin, 1'b1);
        end
        chk("disabled_reads", rd, 0);
        for (int k = 0; k < 12; k++) begin
            begin_cycle();
            if (k == 8) chk("enable_read_early", m_read, 0);
            if (k == 9) chk("enable_read", m_read, 1);
            end_cycle(1'b1, 1'b0, '0, pin, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
